// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-master, one-slave arbiter for the native valid/ready memory bus. The CPU core (M0) and a
//   second requester (M1, loader/DMA) share one single-port memory/MMIO slave. Grants are
//   round-robin with one transaction per grant. A bus watchdog force-completes any transaction
//   the slave never acknowledges.
//
// Parameters
//   TIMEOUT_CYCLES  BUSY cycles without s_ready before forced completion; 0 disables the watchdog
//   ERR_RDATA       read data returned to the master on a timed-out transaction
//
// Ports
//   clk, resetn                      clock, synchronous active-low reset
//   mN_valid/instr/addr/wdata/wstrb  master N request and payload (N = 0, 1); wstrb 0 = read
//   mN_ready, mN_rdata               master N completion pulse and read data
//   s_valid/instr/addr/wdata/wstrb   request and payload of the granted master to the slave
//   s_ready, s_rdata                 slave completion pulse and read data
//   grant                            one-hot owner of the current transaction, 0 when idle
//   err, err_addr, err_clr           sticky timeout flag, first timed-out address, clear

module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,

   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,

   output logic        s_valid,
   output logic        s_instr,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,

   output logic [1:0]  grant,
   output logic        err,
   output logic [31:0] err_addr,
   input  logic        err_clr
);

   // Keep at least one bit so the watchdog-off build still elaborates.
   localparam int unsigned WdogW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e             r_state;
   logic [1:0]         r_grant;
   logic               r_last;
   logic [WdogW-1:0]   r_wdog;
   logic               r_err;
   logic [31:0]        r_err_addr;

   logic               w_busy;
   logic               w_sel;
   logic               w_m_valid;
   logic               w_tmo;
   logic               w_done;
   logic [31:0]        w_rdata;

   // Gated with resetn so nothing reaches the slave or a master while reset is held.
   assign w_busy    = (r_state == StBusy) && resetn;
   assign w_sel     = r_grant[1];
   assign w_m_valid = w_sel ? m1_valid : m0_valid;

   // A same-cycle s_ready beats the watchdog.
   assign w_tmo  = (TIMEOUT_CYCLES != 0) && w_busy && !s_ready && (r_wdog == WdogLast);
   assign w_done = w_busy && (s_ready || w_tmo);

   assign w_rdata = w_tmo ? ERR_RDATA : s_rdata;

   always_comb begin
      s_valid = 1'b0;
      s_instr = 1'b0;
      s_addr  = 32'h0;
      s_wdata = 32'h0;
      s_wstrb = 4'h0;
      if (w_busy) begin
         s_valid = w_m_valid && !w_tmo;
         s_instr = w_sel ? m1_instr : m0_instr;
         s_addr  = w_sel ? m1_addr  : m0_addr;
         s_wdata = w_sel ? m1_wdata : m0_wdata;
         s_wstrb = w_sel ? m1_wstrb : m0_wstrb;
      end
   end

   always_comb begin
      m0_ready = w_done && r_grant[0];
      m1_ready = w_done && r_grant[1];
      m0_rdata = (w_busy && r_grant[0]) ? w_rdata : 32'h0;
      m1_rdata = (w_busy && r_grant[1]) ? w_rdata : 32'h0;
   end

   assign grant    = r_grant;
   assign err      = r_err;
   assign err_addr = r_err_addr;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state    <= StIdle;
         r_grant    <= 2'b00;
         r_last     <= 1'b1;
         r_wdog     <= '0;
         r_err      <= 1'b0;
         r_err_addr <= 32'h0;
      end else begin
         // A new timeout wins over a same-cycle clear; after a clear it is the first again.
         if (w_tmo) begin
            r_err <= 1'b1;
            if (!r_err || err_clr) begin
               r_err_addr <= s_addr;
            end
         end else if (err_clr) begin
            r_err      <= 1'b0;
            r_err_addr <= 32'h0;
         end

         unique case (r_state)
            StIdle: begin
               // On a tie the master that did not own the last transaction wins.
               if (m0_valid && (!m1_valid || r_last)) begin
                  r_grant <= 2'b01;
                  r_state <= StBusy;
               end else if (m1_valid) begin
                  r_grant <= 2'b10;
                  r_state <= StBusy;
               end
            end
            StBusy: begin
               if (w_done) begin
                  r_state <= StIdle;
                  r_last  <= r_grant[1];
                  r_grant <= 2'b00;
                  r_wdog  <= '0;
               end else if (TIMEOUT_CYCLES != 0) begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            default: begin
               r_state <= StIdle;
               r_grant <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        m0_valid, m0_instr, m1_valid, m1_instr;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_valid, s_instr, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic [1:0]  grant;
   logic        err, err_clr;
   logic [31:0] err_addr;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .TIMEOUT_CYCLES(8),
      .ERR_RDATA     (32'hDEAD_BEEF)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .m0_valid(m0_valid),
      .m0_instr(m0_instr),
      .m0_addr (m0_addr),
      .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready),
      .m0_rdata(m0_rdata),
      .m1_valid(m1_valid),
      .m1_instr(m1_instr),
      .m1_addr (m1_addr),
      .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready),
      .m1_rdata(m1_rdata),
      .s_valid (s_valid),
      .s_instr (s_instr),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_wstrb (s_wstrb),
      .s_ready (s_ready),
      .s_rdata (s_rdata),
      .grant   (grant),
      .err     (err),
      .err_addr(err_addr),
      .err_clr (err_clr)
   );

   // Inputs change just after the rising edge; outputs are checked on the falling edge.
   task automatic pedge();
      @(posedge clk);
      #1;
   endtask

   task automatic nedge();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
      m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
      s_ready = 0; s_rdata = 0; err_clr = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      resetn = 0;
      pedge();
      pedge();
      m0_valid = 1;
      s_ready = 1;
      nedge();
      n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL rst_svalid: got %b want 0", s_valid); end
      n_cmp++; if (m0_ready !== 1'b0) begin n_bad++; $display("FAIL rst_m0rdy: got %b want 0", m0_ready); end
      n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rst_grant: got %b want 00", grant); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
      n_cmp++; if (err_addr !== 32'h0) begin n_bad++; $display("FAIL rst_eaddr: got %h want 0", err_addr); end
      pedge();
      clear_inputs();
      resetn = 1;
   endtask

   task automatic test_single_read();
      pedge();
      m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 4'h0;
      nedge();
      n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL rd_idle_svalid: got %b want 0", s_valid); end
      pedge();
      nedge();
      n_cmp++; if (s_valid !== 1'b1) begin n_bad++; $display("FAIL rd_svalid: got %b want 1", s_valid); end
      n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL rd_grant: got %b want 01", grant); end
      n_cmp++; if (s_addr !== 32'h100) begin n_bad++; $display("FAIL rd_saddr: got %h want 100", s_addr); end
      pedge();
      nedge();
      n_cmp++; if (m0_ready !== 1'b0) begin n_bad++; $display("FAIL rd_early_rdy: got %b want 0", m0_ready); end
      pedge();
      s_ready = 1; s_rdata = 32'h1234;
      nedge();
      n_cmp++; if (m0_ready !== 1'b1) begin n_bad++; $display("FAIL rd_m0rdy: got %b want 1", m0_ready); end
      n_cmp++; if (m0_rdata !== 32'h1234) begin n_bad++; $display("FAIL rd_rdata: got %h want 1234", m0_rdata); end
      n_cmp++; if (m1_ready !== 1'b0) begin n_bad++; $display("FAIL rd_m1rdy: got %b want 0", m1_ready); end
      pedge();
      s_ready = 0; s_rdata = 0; m0_valid = 0;
      nedge();
      n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rd_grant_end: got %b want 00", grant); end
      n_cmp++; if (m0_ready !== 1'b0) begin n_bad++; $display("FAIL rd_rdy_end: got %b want 0", m0_ready); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g [4];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      // Fresh reset so M0 wins the first tie.
      resetn = 0;
      pedge();
      pedge();
      resetn = 1;
      m0_valid = 1; m0_addr = 32'hA0;
      m1_valid = 1; m1_addr = 32'hB0;
      for (int i = 0; i < 4; i++) begin
         s_ready = 0;
         nedge();
         n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rr_idle%0d: got %b want 00", i, grant); end
         n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL rr_sv%0d: got %b want 0", i, s_valid); end
         pedge();
         s_ready = 1;
         nedge();
         n_cmp++; if (grant !== exp_g[i]) begin n_bad++; $display("FAIL rr_grant%0d: got %b want %b", i, grant, exp_g[i]); end
         n_cmp++; if ({m1_ready, m0_ready} !== exp_g[i]) begin
            n_bad++; $display("FAIL rr_rdy%0d: got %b want %b", i, {m1_ready, m0_ready}, exp_g[i]);
         end
         n_cmp++; if (s_addr !== (exp_g[i][1] ? 32'hB0 : 32'hA0)) begin
            n_bad++; $display("FAIL rr_addr%0d: got %h", i, s_addr);
         end
         pedge();
      end
      clear_inputs();
      pedge();
   endtask

   task automatic test_m1_write();
      m1_valid = 1; m1_instr = 1; m1_addr = 32'h2000_0000; m1_wdata = 32'h41; m1_wstrb = 4'b0001;
      nedge();
      n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL wr_idle: got %b want 00", grant); end
      pedge();
      nedge();
      n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL wr_grant: got %b want 10", grant); end
      n_cmp++; if (s_valid !== 1'b1) begin n_bad++; $display("FAIL wr_svalid: got %b want 1", s_valid); end
      n_cmp++; if (s_addr !== 32'h2000_0000) begin n_bad++; $display("FAIL wr_addr: got %h want 20000000", s_addr); end
      n_cmp++; if (s_wdata !== 32'h41) begin n_bad++; $display("FAIL wr_wdata: got %h want 41", s_wdata); end
      n_cmp++; if (s_wstrb !== 4'b0001) begin n_bad++; $display("FAIL wr_wstrb: got %b want 0001", s_wstrb); end
      n_cmp++; if (s_instr !== 1'b1) begin n_bad++; $display("FAIL wr_instr: got %b want 1", s_instr); end
      pedge();
      s_ready = 1; s_rdata = 32'h55;
      nedge();
      n_cmp++; if (m1_ready !== 1'b1) begin n_bad++; $display("FAIL wr_m1rdy: got %b want 1", m1_ready); end
      n_cmp++; if (m0_ready !== 1'b0) begin n_bad++; $display("FAIL wr_m0rdy: got %b want 0", m0_ready); end
      n_cmp++; if (m1_rdata !== 32'h55) begin n_bad++; $display("FAIL wr_m1rdata: got %h want 55", m1_rdata); end
      n_cmp++; if (m0_rdata !== 32'h0) begin n_bad++; $display("FAIL wr_m0rdata: got %h want 0", m0_rdata); end
      pedge();
      clear_inputs();
   endtask

   task automatic test_timeout();
      // First timeout: M0 read, slave silent.
      m0_valid = 1; m0_addr = 32'h3000_0000;
      for (int k = 1; k <= 8; k++) begin
         pedge();
         nedge();
         if (k < 8) begin
            n_cmp++; if (m0_ready !== 1'b0) begin n_bad++; $display("FAIL to_early%0d: got %b want 0", k, m0_ready); end
            n_cmp++; if (s_valid !== 1'b1) begin n_bad++; $display("FAIL to_sv%0d: got %b want 1", k, s_valid); end
         end else begin
            n_cmp++; if (m0_ready !== 1'b1) begin n_bad++; $display("FAIL to_rdy: got %b want 1", m0_ready); end
            n_cmp++; if (m0_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL to_rdata: got %h want deadbeef", m0_rdata); end
            n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL to_sv_last: got %b want 0", s_valid); end
         end
      end
      pedge();
      m0_valid = 0;
      nedge();
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", err); end
      n_cmp++; if (err_addr !== 32'h3000_0000) begin n_bad++; $display("FAIL to_eaddr: got %h want 30000000", err_addr); end
      n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL to_grant: got %b want 00", grant); end
      // Second timeout on M1 must not overwrite the recorded address.
      pedge();
      m1_valid = 1; m1_addr = 32'h3000_0040;
      for (int k = 1; k <= 8; k++) begin
         pedge();
      end
      nedge();
      n_cmp++; if (m1_ready !== 1'b1) begin n_bad++; $display("FAIL to2_rdy: got %b want 1", m1_ready); end
      n_cmp++; if (m1_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL to2_rdata: got %h want deadbeef", m1_rdata); end
      pedge();
      m1_valid = 0;
      nedge();
      n_cmp++; if (err_addr !== 32'h3000_0000) begin n_bad++; $display("FAIL to2_eaddr: got %h want 30000000", err_addr); end
      pedge();
      err_clr = 1;
      pedge();
      err_clr = 0;
      nedge();
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL clr_err: got %b want 0", err); end
      n_cmp++; if (err_addr !== 32'h0) begin n_bad++; $display("FAIL clr_eaddr: got %h want 0", err_addr); end
   endtask

   task automatic test_ready_on_last_cycle();
      pedge();
      m0_valid = 1; m0_addr = 32'h3000_0080;
      for (int k = 1; k <= 8; k++) begin
         pedge();
         if (k == 8) begin
            s_ready = 1; s_rdata = 32'hCAFE_F00D;
         end
      end
      nedge();
      n_cmp++; if (m0_ready !== 1'b1) begin n_bad++; $display("FAIL last_rdy: got %b want 1", m0_ready); end
      n_cmp++; if (m0_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL last_rdata: got %h want cafef00d", m0_rdata); end
      n_cmp++; if (s_valid !== 1'b1) begin n_bad++; $display("FAIL last_sv: got %b want 1", s_valid); end
      pedge();
      clear_inputs();
      nedge();
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL last_err: got %b want 0", err); end
   endtask

   task automatic test_idle_ready();
      pedge();
      s_ready = 1; s_rdata = 32'h77;
      nedge();
      n_cmp++; if ({m1_ready, m0_ready} !== 2'b00) begin n_bad++; $display("FAIL idle_rdy: got %b want 00", {m1_ready, m0_ready}); end
      n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL idle_sv: got %b want 0", s_valid); end
      pedge();
      nedge();
      n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL idle_grant: got %b want 00", grant); end
      pedge();
      clear_inputs();
   endtask

   task automatic test_reset_busy();
      m1_valid = 1; m1_addr = 32'h44;
      pedge();
      nedge();
      n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL rb_grant: got %b want 10", grant); end
      n_cmp++; if (s_valid !== 1'b1) begin n_bad++; $display("FAIL rb_sv: got %b want 1", s_valid); end
      pedge();
      resetn = 0; s_ready = 1;
      nedge();
      n_cmp++; if (m1_ready !== 1'b0) begin n_bad++; $display("FAIL rb_rdy: got %b want 0", m1_ready); end
      n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL rb_sv0: got %b want 0", s_valid); end
      pedge();
      nedge();
      n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rb_grant0: got %b want 00", grant); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rb_err: got %b want 0", err); end
      pedge();
      resetn = 1; s_ready = 0; m0_valid = 1; m1_valid = 1;
      pedge();
      nedge();
      n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL rb_next: got %b want 01", grant); end
      pedge();
      s_ready = 1;
      pedge();
      clear_inputs();
      pedge();
   endtask

   initial begin
      #200000;
      $display("FAIL sim_timeout: got no finish want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_m1_write();
      test_timeout();
      test_ready_on_last_cycle();
      test_idle_ready();
      test_reset_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
